instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/def.sv | 14 +
 rtl/instr_fetch_if_pc_gen.sv | 22 ++
 rtl/param.sv | 7 +
 rtl/instr_fetch.sv | 76 +++++++
 tb/tb_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/def.sv
// Shared types for the fetch stage: instruction word type, fetch FSM states, reset PC.
`include "param.sv"
package def;
  typedef logic [`Width-1:0] instrType;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetchState;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int LOG_DEPTH_MEM = `logDepthMem;
endpackage

// File: rtl/instr_fetch_if_pc_gen.sv
// Next-pc selection for fetch: redirect (word aligned) beats +4 advance beats hold.
module if_pc_gen (
  input  logic [31:0] pc,
  input  logic        fetch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_next,
  output logic        misalign
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc & ~32'h3;
    end else if (fetch) begin
      pc_next = pc + 32'd4;
    end
  end

  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/param.sv
// Global sizing macros shared by the fetch slice and instruction memory.
`ifndef PARAM_SV
`define PARAM_SV
`define Width 32
`define logDepthMem 10
`define depthMem 1024
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-word-per-cycle fetch with stall, redirect flush and halt.
module instr_fetch
  import def::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [LOG_DEPTH_MEM-1:0] instrAddress,
  input  instrType                 instr,
  output instrType                 if_instr,
  output logic [31:0]              if_pc,
  output logic                     if_valid,
  input  logic                     id_ready,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     misalign_err
);

  fetchState   state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        misalign;
  logic        fetch;

  assign instrAddress = pc[LOG_DEPTH_MEM+1:2];

  // Halt suppresses the fetch in the same cycle it is raised.
  assign fetch = (state == RUN) && (!if_valid || id_ready) && !redirect_valid && !halt;

  if_pc_gen u_pc_gen (
    .pc            (pc),
    .fetch         (fetch),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_next       (pc_next),
    .misalign      (misalign)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (halt) state_nxt = HALT;
      HALT:    if (redirect_valid && !halt) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_next;
      if (misalign) misalign_err <= 1'b1;
      // Flush wins over everything; otherwise refill, or drop a consumed word.
      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (fetch) begin
        if_instr <= instr;
        if_pc    <= pc;
        if_valid <= 1'b1;
      end else if (id_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed checks of instr_fetch against a rule-level reference model.
module tb_instr_fetch;
  import def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;

  logic [LOG_DEPTH_MEM-1:0] instrAddress, instrAddress1;
  instrType    instr, instr1, if_instr, if_instr1;
  logic [31:0] if_pc, if_pc1;
  logic        if_valid, if_valid1, misalign_err, misalign_err1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h1000_0000 + k.
  assign instr  = 32'h1000_0000 + 32'(instrAddress);
  assign instr1 = 32'h1000_0000 + 32'(instrAddress1);

  instr_fetch dut (
    .clk(clk), .rst(rst), .instrAddress(instrAddress), .instr(instr),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .misalign_err(misalign_err)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .instrAddress(instrAddress1), .instr(instr1),
    .if_instr(if_instr1), .if_pc(if_pc1), .if_valid(if_valid1), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .misalign_err(misalign_err1)
  );

  // Reference model of the default-RESET_PC instance.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_state;
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    return 32'h1000_0000 + ((byte_addr / 4) % 1024);
  endfunction

  function automatic logic [75:0] model_vec();
    logic [9:0] wa;
    wa = 10'((m_pc / 4) % 1024);
    return {m_valid, m_ifpc, m_instr, m_mis, wa};
  endfunction

  function automatic logic [75:0] dut_vec();
    return {if_valid, if_pc, if_instr, misalign_err, instrAddress};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_update(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic hlt);
    if (rv) begin
      m_valid = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
      if (rpc % 4 != 0) m_mis = 1'b1;
      m_state = (m_state != M_IDLE && hlt) ? M_HALT : M_RUN;
    end else if (m_state == M_IDLE) begin
      if (rdy) m_valid = 1'b0;
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (hlt) begin
        if (rdy) m_valid = 1'b0;
        m_state = M_HALT;
      end else if (!m_valid || rdy) begin
        m_instr = mem_word(m_pc);
        m_ifpc  = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end else begin
      if (rdy) m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hlt);
    id_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt = hlt;
    @(posedge clk);
    model_update(rdy, rv, rpc, hlt);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (dut_vec() !== 76'h0) begin
      fails++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 76'h0);
    end
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++; $display("FAIL idle_cycle if_valid got=%b want=0", if_valid);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      fails++; $display("FAIL first_fetch got v=%b pc=%h i=%h want v=1 pc=0 i=10000000",
                        if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      tests++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k)}) begin
        fails++; $display("FAIL stream_%0d got v=%b pc=%h i=%h want pc=%h i=%h", k, if_valid,
                          if_pc, if_instr, 32'(4 * k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      tests++;
      if ({if_valid, if_pc, if_instr, instrAddress} !== {1'b1, 32'h8, 32'h1000_0002, 10'd3}) begin
        fails++; $display("FAIL stall_%0d got v=%b pc=%h i=%h a=%0d want pc=8 i=10000002 a=3",
                          c, if_valid, if_pc, if_instr, instrAddress);
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, if_pc} !== {1'b1, 32'hC}) begin
      fails++; $display("FAIL stall_release got v=%b pc=%h want v=1 pc=c", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b1, 32'h40, 1'b0);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++; $display("FAIL redirect_flush got v=%b want 0", if_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'h1000_0010}) begin
      fails++; $display("FAIL redirect_target got v=%b pc=%h i=%h want pc=40 i=10000010",
                        if_valid, if_pc, if_instr);
    end
    step(1'b1, 1'b1, 32'h42, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, if_pc, misalign_err} !== {1'b1, 32'h40, 1'b1}) begin
      fails++; $display("FAIL misalign got v=%b pc=%h err=%b want v=1 pc=40 err=1",
                        if_valid, if_pc, misalign_err);
    end
    repeat (5) step(1'(($urandom & 1)), 1'b0, 32'h0, 1'b0);
    tests++;
    if (misalign_err !== 1'b1) begin
      fails++; $display("FAIL misalign_sticky got=%b want 1", misalign_err);
    end
    do_reset();
    tests++;
    if (misalign_err !== 1'b0) begin
      fails++; $display("FAIL misalign_clear got=%b want 0", misalign_err);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (7) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    tests++;
    if ({if_valid, if_pc} !== {1'b1, 32'd20}) begin
      fails++; $display("FAIL halt_hold got v=%b pc=%h want v=1 pc=14", if_valid, if_pc);
    end
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'(($urandom & 1)));
    tests++;
    if ({if_valid, instrAddress} !== {1'b0, 10'd6}) begin
      fails++; $display("FAIL halt_idle got v=%b a=%0d want v=0 a=6", if_valid, instrAddress);
    end
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL halt_resume got v=%b pc=%h want v=1 pc=0", if_valid, if_pc);
    end
    step(1'b1, 1'b1, 32'h100, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid, instrAddress} !== {1'b0, 10'h40}) begin
      fails++; $display("FAIL halt_redirect got v=%b a=%h want v=0 a=40", if_valid, instrAddress);
    end
  endtask

  task automatic test_random();
    logic        rdy, rv, hlt;
    logic [31:0] rpc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 6);
      rv  = ($urandom_range(0, 9) == 0);
      hlt = ($urandom_range(0, 14) == 0);
      rpc = (($urandom & 3) == 0) ? $urandom : ($urandom & 32'h0000_1FFC);
      if (c == 200) begin
        do_reset();
        continue;
      end
      step(rdy, rv, rpc, hlt);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random_cycle_%0d got=%h want=%h", c, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid1, if_pc1, if_instr1} !== {1'b1, 32'hFFFF_FFFC, 32'h1000_03FF}) begin
      fails++; $display("FAIL wrap_first got v=%b pc=%h i=%h want pc=fffffffc i=100003ff",
                        if_valid1, if_pc1, if_instr1);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid1, if_pc1, if_instr1} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      fails++; $display("FAIL wrap_zero got v=%b pc=%h i=%h want pc=0 i=10000000",
                        if_valid1, if_pc1, if_instr1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #3 rst = 1'b0;
    #1;
    tests++;
    if ({if_valid1, if_valid, instrAddress1, instrAddress} !== {2'b00, 10'h3FF, 10'h0}) begin
      fails++; $display("FAIL reset_mid_stall got v1=%b v0=%b a1=%h a0=%h want 0 0 3ff 0",
                        if_valid1, if_valid, instrAddress1, instrAddress);
    end
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({if_valid1, if_pc1} !== {1'b1, 32'hFFFF_FFFC}) begin
      fails++; $display("FAIL wrap_restart got v=%b pc=%h want pc=fffffffc", if_valid1, if_pc1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
